// File: rtl/div_16b_mc_ctrl.sv
// Multicycle control wrapper around a 16-bit combinational divider: operand/result handshakes,
// settle timer and divide-by-zero bypass. Define DIV_SIGNED_EN for two's complement operation.
module div_16b_mc_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_dividend,
  input  logic [15:0] in_divisor,
  output logic [15:0] div_dividend,
  output logic [15:0] div_divisor,
  input  logic [15:0] div_quotient,
  input  logic [15:0] div_remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_quotient,
  output logic [15:0] out_remainder,
  output logic        out_dbz,
  output logic        busy
);

  // state  | meaning
  // IDLE   | waiting for an operand pair
  // SETTLE | divider inputs held, counting down to capture
  // DONE   | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  assign in_ready = (state == IDLE);

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  // 0x8000 maps onto itself, which the unsigned divider handles as 32768.
  function automatic logic [15:0] mag(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      div_dividend  <= 16'd0;
      div_divisor   <= 16'd0;
      out_quotient  <= 16'd0;
      out_remainder <= 16'd0;
      out_dbz       <= 1'b0;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef DIV_SIGNED_EN
            div_dividend <= mag(in_dividend);
            div_divisor  <= mag(in_divisor);
            neg_q        <= in_dividend[15] ^ in_divisor[15];
            neg_r        <= in_dividend[15];
`else
            div_dividend <= in_dividend;
            div_divisor  <= in_divisor;
`endif
            busy <= 1'b1;
            if (in_divisor == 16'd0) begin
              // divider output is meaningless here, so skip the settle wait entirely
              state         <= DONE;
              out_quotient  <= 16'hFFFF;
              out_remainder <= in_dividend;
              out_dbz       <= 1'b1;
              out_valid     <= 1'b1;
            end else begin
              state   <= SETTLE;
              cnt     <= CNT_LOAD;
              out_dbz <= 1'b0;
            end
          end
        end
        SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
`ifdef DIV_SIGNED_EN
            out_quotient  <= neg_q ? (~div_quotient + 16'd1) : div_quotient;
            out_remainder <= neg_r ? (~div_remainder + 16'd1) : div_remainder;
`else
            out_quotient  <= div_quotient;
            out_remainder <= div_remainder;
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_16b_mc_ctrl.sv
// Scoreboard bench for div_16b_mc_ctrl: randomized and directed operands, arithmetic reference
// model, latency/hold/back-to-back checks, plus a second instance with SETTLE_CYCLES=1.
module tb_div_16b_mc_ctrl;
  localparam int S_A = 2;
  localparam int S_B = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_dbz, busy;
  logic [15:0] in_dividend, in_divisor, div_dividend, div_divisor;
  logic [15:0] div_quotient, div_remainder, out_quotient, out_remainder;

  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_dbz_b, busy_b;
  logic [15:0] in_dividend_b, in_divisor_b, div_dividend_b, div_divisor_b;
  logic [15:0] div_quotient_b, div_remainder_b, out_quotient_b, out_remainder_b;

  // Behavioural stand-in for the combinational divider; junk on zero divisor.
  assign div_quotient    = (div_divisor == 16'd0) ? 16'hDEAD : div_dividend / div_divisor;
  assign div_remainder   = (div_divisor == 16'd0) ? 16'hBEEF : div_dividend % div_divisor;
  assign div_quotient_b  = (div_divisor_b == 16'd0) ? 16'hDEAD : div_dividend_b / div_divisor_b;
  assign div_remainder_b = (div_divisor_b == 16'd0) ? 16'hBEEF : div_dividend_b % div_divisor_b;

  div_16b_mc_ctrl #(.SETTLE_CYCLES(S_A)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_dbz(out_dbz), .busy(busy)
  );

  div_16b_mc_ctrl #(.SETTLE_CYCLES(S_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_dividend(in_dividend_b), .in_divisor(in_divisor_b),
    .div_dividend(div_dividend_b), .div_divisor(div_divisor_b),
    .div_quotient(div_quotient_b), .div_remainder(div_remainder_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_quotient(out_quotient_b), .out_remainder(out_remainder_b),
    .out_dbz(out_dbz_b), .busy(busy_b)
  );

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t sbb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   rand_on;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference model straight from the arithmetic definition.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.acc = 0;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1; e.lat = 0;
    end else begin
`ifdef DIV_SIGNED_EN
      int sa = int'($signed(a));
      int sd = int'($signed(b));
      e.q = 16'(sa / sd);
      e.r = 16'(sa % sd);
`else
      e.q = 16'(int'(a) / int'(b));
      e.r = 16'(int'(a) % int'(b));
`endif
      e.dbz = 1'b0; e.lat = S_A;
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit keep, output int acc_cyc);
    exp_t e;
    int t = 0;
    in_dividend = a; in_divisor = b; in_valid = 1'b1;
    while (!in_ready && t < 200) begin step(); t++; end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0; acc_cyc = -1;
      return;
    end
    e = model(a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    acc_cyc = e.acc;
    step();
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() > 0; t++) step();
    chk("drain_timeout", 64'(sb.size()), 64'(0));
  endtask

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'(0));
        end else begin
          if (!prev_valid) chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
          chk("quotient", 64'(out_quotient), 64'(sb[0].q));
          chk("remainder", 64'(out_remainder), 64'(sb[0].r));
          chk("dbz", 64'(out_dbz), 64'(sb[0].dbz));
          chk("ready_busy_done", 64'({in_ready, busy}), 64'(2'b01));
          if (out_ready) void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && cyc >= sb[0].acc) begin
        chk("ready_busy_pending", 64'({in_ready, busy}), 64'(2'b01));
      end
      prev_valid <= out_valid;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_b) begin
      if (sbb.size() == 0) begin
        chk("s1_unexpected_valid", 64'(out_valid_b), 64'(0));
      end else begin
        chk("s1_quotient", 64'(out_quotient_b), 64'(sbb[0].q));
        chk("s1_remainder", 64'(out_remainder_b), 64'(sbb[0].r));
        if (out_ready_b) void'(sbb.pop_front());
      end
    end
  end

  task automatic run_b();
    exp_t e;
    int prev = -1;
    int nb = 0;
    int t = 0;
    out_ready_b = 1'b1;
    in_dividend_b = 16'($urandom);
    in_divisor_b = 16'($urandom_range(1, 65535));
    in_valid_b = 1'b1;
    while (nb < 6 && t < 200) begin
      if (in_ready_b) begin
        e = model(in_dividend_b, in_divisor_b);
        sbb.push_back(e);
        if (prev >= 0) chk("s1_b2b_spacing", 64'(cyc + 1 - prev), 64'(S_B + 2));
        prev = cyc + 1;
        nb++;
        step();
        in_dividend_b = 16'($urandom);
        in_divisor_b = 16'($urandom_range(1, 65535));
      end else begin
        step();
      end
      t++;
    end
    in_valid_b = 1'b0;
    chk("s1_accepts", 64'(nb), 64'(6));
    for (int k = 0; k < 50 && sbb.size() > 0; k++) step();
    chk("s1_drain", 64'(sbb.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", passed, checks);
    $fatal(1);
  end

  initial begin
    int acc, prev;
    rst_n = 1'b0;
    in_valid = 1'b0; in_dividend = 16'd0; in_divisor = 16'd0; out_ready = 1'b1;
    in_valid_b = 1'b0; in_dividend_b = 16'd0; in_divisor_b = 16'd0; out_ready_b = 1'b1;
    repeat (3) step();
    chk("rst_flags", 64'({out_valid, out_dbz, busy, in_ready}), 64'(4'b0001));
    chk("rst_data", {out_quotient, out_remainder, div_dividend, div_divisor}, 64'(0));
    chk("rst_flags_s1", 64'({out_valid_b, busy_b, in_ready_b}), 64'(3'b001));
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    issue(16'd100, 16'd7, 1'b0, acc);
    drain();

    issue(16'h1234, 16'd0, 1'b0, acc);
    drain();

    out_ready = 1'b0;
    issue(16'hFFFF, 16'h0010, 1'b0, acc);
    for (int t = 0; t < 50 && !out_valid; t++) step();
    in_dividend = 16'd7; in_divisor = 16'd2; in_valid = 1'b1;
    repeat (5) begin
      step();
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    issue(16'd7, 16'd2, 1'b0, acc);
    drain();

    issue(16'd500, 16'd3, 1'b0, acc);
    rst_n = 1'b0;
    sb.delete();
    step();
    chk("midop_rst", 64'({out_valid, busy, in_ready}), 64'(3'b001));
    rst_n = 1'b1;
    step();
    chk("post_rst", 64'({out_valid, busy, in_ready}), 64'(3'b001));
    issue(16'd9, 16'd4, 1'b0, acc);
    drain();

`ifdef DIV_SIGNED_EN
    issue(16'hFF9C, 16'd7, 1'b0, acc);
    issue(16'd100, 16'hFFF9, 1'b0, acc);
    issue(16'h8000, 16'hFFFF, 1'b0, acc);
    issue(16'h8000, 16'd0, 1'b0, acc);
    drain();
`endif

    prev = -1;
    for (int i = 0; i < 6; i++) begin
      issue(16'($urandom), 16'($urandom_range(1, 65535)), 1'b1, acc);
      if (prev >= 0) chk("b2b_spacing", 64'(acc - prev), 64'(S_A + 2));
      prev = acc;
    end
    in_valid = 1'b0;
    drain();

    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          issue(16'($urandom), ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom), 1'b0, acc);
          repeat ($urandom_range(0, 2)) step();
        end
        drain();
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          step();
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join

    run_b();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/div_16b_mc_ctrl.md
Name: div_16b_mc_ctrl

Overview:
- Sequential control stage wrapped around the 16-bit combinational unsigned divider; treats the divider as a multicycle path.
- Upstream side: accepts operand pairs on a valid/ready handshake and registers them to drive the divider inputs.
- Waits a fixed settle time, then captures quotient and remainder.
- Downstream side: presents the result on a valid/ready handshake. Divide-by-zero is detected and flagged here, and the divider is bypassed for it.

Parameters:
- SETTLE_CYCLES, 2, cycles the divider outputs are given to settle before capture; legal range 1..15; 4-bit counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_dividend  in  16  dividend
- in_divisor  in  16  divisor
- div_dividend  out  16  registered dividend to divider
- div_divisor  out  16  registered divisor to divider
- div_quotient  in  16  quotient from divider
- div_remainder  in  16  remainder from divider
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_quotient  out  16  captured quotient
- out_remainder  out  16  captured remainder
- out_dbz  out  1  divide-by-zero flag for current result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, counter=0.
  - All data registers are 0.
  - out_valid=0, out_dbz=0, busy=0, in_ready=1.
  - Reset mid-operation aborts the operation and discards the result.
- FSM states: IDLE, SETTLE, DONE.
- in_ready = (state==IDLE), combinational from state only.
- IDLE:
  - On the accept edge (in_valid & in_ready), register the operands into div_dividend and div_divisor.
  - If in_divisor==0: go to DONE. Load out_quotient=0xFFFF, out_remainder=in_dividend, out_dbz=1.
  - Otherwise: go to SETTLE, load counter=SETTLE_CYCLES-1, out_dbz=0.
- SETTLE:
  - Each edge with counter!=0 decrements the counter.
  - On the edge with counter==0: capture div_quotient and div_remainder into the out registers and go to DONE.
  - div_dividend and div_divisor stay stable throughout SETTLE.
- DONE:
  - out_valid=1.
  - out_quotient, out_remainder and out_dbz are held stable until out_ready.
  - On the edge where out_valid & out_ready, go to IDLE and drop out_valid.
- Latency, measured from the accept edge:
  - Nonzero divisor: out_valid visible after SETTLE_CYCLES+1 edges.
  - Zero divisor: out_valid visible after 1 edge.
- Throughput: no new operand is accepted until the result handshake completes.
  - Minimum issue interval is SETTLE_CYCLES+2 cycles, assuming out_ready is held high.
- Operand handling:
  - in_valid while busy is ignored; the operand is not consumed, since in_ready=0.
  - Operand values presented when in_valid=0 are don't-care.
- Out registers keep their last result after returning to IDLE. Only out_valid qualifies them.
- Unsigned arithmetic only, unless the optional feature below is compiled in.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- With the macro defined, operands and results are 16-bit two's complement.
  - The divider is driven with operand magnitudes; |-32768| = 0x8000, which the unsigned divider handles.
  - At capture, the quotient is negated if the operand signs differ.
  - The remainder takes the sign of the dividend (truncating division).
  - -32768 / -1 gives quotient 0x8000 and remainder 0x0000, with no extra flag.
  - Divide-by-zero gives quotient 0xFFFF (-1), remainder = original signed dividend, out_dbz=1.
  - Latency is unchanged.
- Without the macro: pure unsigned behaviour and no sign logic is synthesized.

Test Plan:
1. Reset, then 100/7 with SETTLE_CYCLES=2 and out_ready=1 → out_valid after 3 edges. q=14, r=2, dbz=0. in_ready low for the duration.
2. 0x1234/0 → out_valid after 1 edge. q=0xFFFF, r=0x1234, dbz=1. div_quotient is not sampled.
3. 0xFFFF/0x0010 with out_ready=0 for 5 cycles → q=0x0FFF, r=0x000F held stable with out_valid=1. A second in_valid during the hold is not accepted. The result is accepted when out_ready rises, and the next operand is then accepted in IDLE.
4. Accept 500/3, then assert rst_n=0 during SETTLE → immediate IDLE. out_valid=0, busy=0, in_ready=1 after release. The next op 9/4 gives q=2, r=1.
5. DIV_SIGNED_EN defined: -100/7 → q=0xFFF2, r=0xFFFE. 100/-7 → q=0xFFF2, r=0x0002. -32768/-1 → q=0x8000, r=0.
6. Back-to-back ops with in_valid and out_ready held high → accept edges spaced SETTLE_CYCLES+2 cycles apart. Repeat with SETTLE_CYCLES=1; spacing 3.
